// File: rtl/xgmii2fifo72.sv
// xgmii2fifo72 - receive-side XGMII framer feeding a 72-bit switch FIFO.
// Strips inter-frame idles, writes only frame words as {ctrl[7:0], data[63:0]},
// drops whole frames when the FIFO lacks room at frame start, and closes a
// frame with an error word when the FIFO overflows mid-frame.
//
// Ports:
//   xgmii_rx_clk  in   1  sole clock, also the FIFO write clock
//   sys_rst_n     in   1  synchronous active-low reset
//   xgmii_rxd     in  72  {rxc[7:0], rxd[63:0]}, lane k = rxd[8k+7:8k] / rxc[k]
//   din           out 72  FIFO write data, same format
//   wr_en         out  1  FIFO write strobe
//   wr_clk        out  1  copy of xgmii_rx_clk
//   full          in   1  FIFO full
//   almost_full   in   1  FIFO programmable full (room for one max frame)
//   frame_cnt     out 32  frames accepted
//   drop_cnt      out 32  frames dropped at start
//   err_cnt       out 32  frames aborted by overflow or restart
//
// Build option: define XGMII2FIFO_STATS_EN to implement the three counters;
// otherwise they are tied to zero and framing is unchanged.

module xgmii2fifo72 (
   input  logic        xgmii_rx_clk,
   input  logic        sys_rst_n,
   input  logic [71:0] xgmii_rxd,
   output logic [71:0] din,
   output logic        wr_en,
   output logic        wr_clk,
   input  logic        full,
   input  logic        almost_full,
   output logic [31:0] frame_cnt,
   output logic [31:0] drop_cnt,
   output logic [31:0] err_cnt
);

   localparam logic [71:0] IDLE_WORD = 72'hff_07070707_07070707;
   localparam logic [71:0] ERR_WORD  = 72'hff_fefefefe_fefefefe;

   typedef enum logic [1:0] {IDLE, FRAME, DROP, ABORT} state_t;

   state_t      state, state_nxt;
   logic        abort_term, abort_term_nxt;
   logic        wr_nxt;
   logic [71:0] din_nxt;
   logic        frame_inc, drop_inc, err_inc;

   logic [7:0]  ctrl_in;
   logic [63:0] data_in;
   logic [7:0]  term_lane;
   logic        start0, start4, is_start, term_any;
   logic        term_after_start, term_before_start;

   assign wr_clk  = xgmii_rx_clk;
   assign ctrl_in = xgmii_rxd[71:64];
   assign data_in = xgmii_rxd[63:0];

   always_comb begin
      term_lane = '0;
      for (int unsigned k = 0; k < 8; k++)
         term_lane[k] = ctrl_in[k] && (data_in[8*k +: 8] == 8'hFD);
   end

   assign start0   = ctrl_in[0] && (data_in[7:0]   == 8'hFB);
   assign start4   = ctrl_in[4] && (data_in[39:32] == 8'hFB);
   assign is_start = start0 || start4;
   assign term_any = |term_lane;

   // Lane-0 start wins if both lanes carry 0xFB. A terminate before a lane-4
   // start legitimately closes the previous frame in the same word.
   assign term_after_start  = start0 ? |term_lane[7:1] : |term_lane[7:5];
   assign term_before_start = !start0 && |term_lane[3:0];

   always_comb begin
      state_nxt      = state;
      abort_term_nxt = abort_term;
      wr_nxt         = 1'b0;
      din_nxt        = din;
      frame_inc      = 1'b0;
      drop_inc       = 1'b0;
      err_inc        = 1'b0;
      case (state)
         IDLE, DROP: begin
            if (is_start) begin
               if (almost_full || full) begin
                  drop_inc  = 1'b1;
                  state_nxt = term_after_start ? IDLE : DROP;
               end else begin
                  wr_nxt    = 1'b1;
                  din_nxt   = xgmii_rxd;
                  frame_inc = 1'b1;
                  state_nxt = term_after_start ? IDLE : FRAME;
               end
            end else if (state == DROP && term_any) begin
               state_nxt = IDLE;
            end
         end
         FRAME: begin
            if (full) begin
               err_inc        = 1'b1;
               abort_term_nxt = term_any;
               state_nxt      = ABORT;
            end else begin
               wr_nxt  = 1'b1;
               din_nxt = xgmii_rxd;
               if (is_start) begin
                  frame_inc = 1'b1;
                  err_inc   = !term_before_start;
                  state_nxt = term_after_start ? IDLE : FRAME;
               end else if (term_any) begin
                  state_nxt = IDLE;
               end
            end
         end
         ABORT: begin
            // Leave only after the error word is out; if the aborted frame
            // has not terminated yet, keep discarding it in DROP.
            if (!full) begin
               wr_nxt    = 1'b1;
               din_nxt   = ERR_WORD;
               state_nxt = (abort_term || term_any) ? IDLE : DROP;
            end else begin
               abort_term_nxt = abort_term || term_any;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge xgmii_rx_clk) begin
      if (!sys_rst_n) begin
         state      <= IDLE;
         abort_term <= 1'b0;
         wr_en      <= 1'b0;
         din        <= IDLE_WORD;
      end else begin
         state      <= state_nxt;
         abort_term <= abort_term_nxt;
         wr_en      <= wr_nxt;
         din        <= din_nxt;
      end
   end

`ifdef XGMII2FIFO_STATS_EN
   always_ff @(posedge xgmii_rx_clk) begin
      if (!sys_rst_n) begin
         frame_cnt <= '0;
         drop_cnt  <= '0;
         err_cnt   <= '0;
      end else begin
         if (frame_inc) frame_cnt <= frame_cnt + 32'd1;
         if (drop_inc)  drop_cnt  <= drop_cnt + 32'd1;
         if (err_inc)   err_cnt   <= err_cnt + 32'd1;
      end
   end
`else
   assign frame_cnt = '0;
   assign drop_cnt  = '0;
   assign err_cnt   = '0;

   logic unused_stats;
   assign unused_stats = ^{frame_inc, drop_inc, err_inc};
`endif

endmodule

// File: tb/tb_xgmii2fifo72.sv
// tb_xgmii2fifo72 - scoreboard bench for xgmii2fifo72.
// Stimulus pushes each expected FIFO write (word and write cycle) into a
// queue; a monitor pops and compares whenever wr_en is seen.

module tb_xgmii2fifo72;

   localparam logic [71:0] IDLE_W = 72'hff_07070707_07070707;
   localparam logic [71:0] ERR_W  = 72'hff_fefefefe_fefefefe;
   localparam logic [71:0] S0_W   = 72'h01_d5555555_555555fb;  // start lane 0
   localparam logic [71:0] S4_W   = 72'h1f_555555fb_07070707;  // start lane 4
   localparam logic [71:0] T3_W   = 72'hf8_07070707_fdaabbcc;  // terminate lane 3
   localparam logic [71:0] S0T5_W = 72'he1_0707fd44_332211fb;  // start 0 + term 5

   logic        clk = 1'b0;
   logic        sys_rst_n;
   logic [71:0] xgmii_rxd;
   logic [71:0] din;
   logic        wr_en;
   logic        wr_clk;
   logic        full;
   logic        almost_full;
   logic [31:0] frame_cnt;
   logic [31:0] drop_cnt;
   logic [31:0] err_cnt;

   always #5 clk = ~clk;

   xgmii2fifo72 dut (
      .xgmii_rx_clk (clk),
      .sys_rst_n    (sys_rst_n),
      .xgmii_rxd    (xgmii_rxd),
      .din          (din),
      .wr_en        (wr_en),
      .wr_clk       (wr_clk),
      .full         (full),
      .almost_full  (almost_full),
      .frame_cnt    (frame_cnt),
      .drop_cnt     (drop_cnt),
      .err_cnt      (err_cnt)
   );

   typedef struct {
      logic [71:0] word;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int unsigned m_frame = 0, m_drop = 0, m_err = 0;

   // Monitor: cyc counts rising edges; outputs sampled 1 time unit after.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (wr_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: din=%h at cycle %0d, required no write", din, cyc);
            end else begin
               e = sb.pop_front();
               if (din !== e.word || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL write_data: got %h at cycle %0d, required %h at cycle %0d",
                           din, cyc, e.word, e.cyc);
               end
            end
         end
      end
   end

   function automatic logic [71:0] dw(input int unsigned i);
      return {8'h00, 32'hda7a0000 + 32'(i), 32'h12340000 + 32'(i * 3)};
   endfunction

   task automatic drive(input logic [71:0] w, input logic f, input logic af);
      @(negedge clk);
      xgmii_rxd   = w;
      full        = f;
      almost_full = af;
   endtask

   // Expect a write of w at the rising edge that samples the current drive.
   task automatic expect_w(input logic [71:0] w);
      exp_t e;
      e.word = w;
      e.cyc  = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic chk_cnt(input string tag);
`ifdef XGMII2FIFO_STATS_EN
      chk({tag, "_frame_cnt"}, 72'(frame_cnt), 72'(m_frame));
      chk({tag, "_drop_cnt"},  72'(drop_cnt),  72'(m_drop));
      chk({tag, "_err_cnt"},   72'(err_cnt),   72'(m_err));
`else
      chk({tag, "_frame_cnt"}, 72'(frame_cnt), 72'd0);
      chk({tag, "_drop_cnt"},  72'(drop_cnt),  72'd0);
      chk({tag, "_err_cnt"},   72'(err_cnt),   72'd0);
`endif
   endtask

   task automatic flush(input string tag, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) drive(IDLE_W, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_pending: got %0d writes outstanding, required 0", tag, sb.size());
         sb.delete();
      end
      chk_cnt(tag);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_wr_en"}, 72'(wr_en), 72'd0);
      chk({tag, "_din"}, din, IDLE_W);
      chk_cnt(tag);
   endtask

   initial begin
      sys_rst_n   = 1'b0;
      xgmii_rxd   = IDLE_W;
      full        = 1'b0;
      almost_full = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      sys_rst_n = 1'b1;

      // Lane-0 start, 6 data words, terminate on lane 3 of word 8
      flush("pre", 3);
      drive(S0_W, 1'b0, 1'b0); expect_w(S0_W); m_frame++;
      for (int unsigned i = 1; i <= 6; i++) begin
         drive(dw(i), 1'b0, 1'b0); expect_w(dw(i));
      end
      drive(T3_W, 1'b0, 1'b0); expect_w(T3_W);
      flush("frame8", 3);

      // Start and terminate in one word: following data word is not written
      drive(S0T5_W, 1'b0, 1'b0); expect_w(S0T5_W); m_frame++;
      drive(dw(50), 1'b0, 1'b0);
      flush("oneword", 2);

      // Lane-4 start written as received
      drive(S4_W, 1'b0, 1'b0); expect_w(S4_W); m_frame++;
      for (int unsigned i = 10; i < 13; i++) begin
         drive(dw(i), 1'b0, 1'b0); expect_w(dw(i));
      end
      drive(T3_W, 1'b0, 1'b0); expect_w(T3_W);
      flush("lane4", 2);

      // almost_full at start of a 10-word frame, cleared on word 3
      drive(S0_W, 1'b0, 1'b1); m_drop++;
      drive(dw(20), 1'b0, 1'b1);
      for (int unsigned i = 3; i <= 9; i++) drive(dw(20 + i), 1'b0, 1'b0);
      drive(T3_W, 1'b0, 1'b0);
      drive(S0_W, 1'b0, 1'b0); expect_w(S0_W); m_frame++;
      drive(dw(30), 1'b0, 1'b0); expect_w(dw(30));
      drive(dw(31), 1'b0, 1'b0); expect_w(dw(31));
      drive(T3_W, 1'b0, 1'b0); expect_w(T3_W);
      flush("drop", 2);

      // Dropped frame without terminate, then a start accepted from DROP
      drive(S0_W, 1'b0, 1'b1); m_drop++;
      drive(dw(35), 1'b0, 1'b0);
      drive(S0_W, 1'b0, 1'b0); expect_w(S0_W); m_frame++;
      drive(dw(36), 1'b0, 1'b0); expect_w(dw(36));
      drive(T3_W, 1'b0, 1'b0); expect_w(T3_W);
      flush("droprestart", 2);

      // full on words 4-6 of a 10-word frame: error word on word 7
      drive(S0_W, 1'b0, 1'b0); expect_w(S0_W); m_frame++;
      drive(dw(40), 1'b0, 1'b0); expect_w(dw(40));
      drive(dw(41), 1'b0, 1'b0); expect_w(dw(41));
      drive(dw(42), 1'b1, 1'b1); m_err++;
      drive(dw(43), 1'b1, 1'b1);
      drive(dw(44), 1'b1, 1'b1);
      drive(dw(45), 1'b0, 1'b0); expect_w(ERR_W);
      drive(dw(46), 1'b0, 1'b0);
      drive(dw(47), 1'b0, 1'b0);
      drive(T3_W, 1'b0, 1'b0);
      flush("overflow", 2);

      // Reset on word 5 of a frame
      drive(S0_W, 1'b0, 1'b0); expect_w(S0_W); m_frame++;
      for (int unsigned i = 2; i <= 4; i++) begin
         drive(dw(60 + i), 1'b0, 1'b0); expect_w(dw(60 + i));
      end
      drive(dw(65), 1'b0, 1'b0);
      sys_rst_n = 1'b0;
      @(negedge clk);
      sys_rst_n = 1'b1;
      m_frame = 0; m_drop = 0; m_err = 0;
      chk_reset("midreset");
      drive(dw(66), 1'b0, 1'b0);
      drive(dw(67), 1'b0, 1'b0);
      drive(T3_W, 1'b0, 1'b0);
      drive(S0_W, 1'b0, 1'b0); expect_w(S0_W); m_frame++;
      drive(dw(70), 1'b0, 1'b0); expect_w(dw(70));
      drive(T3_W, 1'b0, 1'b0); expect_w(T3_W);
      flush("postreset", 2);

      // Start while in FRAME (missing terminate)
      drive(S0_W, 1'b0, 1'b0); expect_w(S0_W); m_frame++;
      drive(dw(80), 1'b0, 1'b0); expect_w(dw(80));
      drive(dw(81), 1'b0, 1'b0); expect_w(dw(81));
      drive(S0_W, 1'b0, 1'b0); expect_w(S0_W); m_frame++; m_err++;
      drive(dw(82), 1'b0, 1'b0); expect_w(dw(82));
      drive(dw(83), 1'b0, 1'b0); expect_w(dw(83));
      drive(T3_W, 1'b0, 1'b0); expect_w(T3_W);
      flush("restart", 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
